// File: rtl/data_memory_bytelane_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_bytelane_if
//  Description : Request/response bundle of the byte-lane data memory.
//                The CPU side drives the request fields. The memory drives
//                ready, the load data and the one-cycle status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_bytelane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              err_misalign;
  logic              err_range;

  modport master (
    output mem_read, mem_write, mem_size, mem_signed, address, din,
    input  ready, dout, dout_valid, err_misalign, err_range
  );

  modport slave (
    input  mem_read, mem_write, mem_size, mem_signed, address, din,
    output ready, dout, dout_valid, err_misalign, err_range
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_bytelane
//  Description : Big-endian, byte-addressed data memory with byte, half,
//                word and dword accesses. Reads have one registered cycle of
//                latency and are zero- or sign-extended. Misaligned and
//                out-of-range accesses are flagged. After reset, an init
//                sequencer clears the whole array before ready rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_bytelane #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_W      = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  data_memory_bytelane_if.slave  bus
);
  localparam int c_NB    = DATA_W / 8;
  localparam int c_NW    = DEPTH_BYTES / c_NB;
  localparam int c_BA_W  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int c_CNT_W = (c_NW > 1) ? $clog2(c_NW) : 1;
  localparam int c_BIT_W = $clog2(DATA_W);
  localparam logic [1:0]         c_SZ_MAX = 2'($clog2(c_NB));
  localparam logic [ADDR_W:0]    c_DEPTH  = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(c_NW - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_init_cnt;
  logic                r_ready;
  logic                r_dout_valid;
  logic                r_err_mis;
  logic                r_err_rng;
  logic [DATA_W-1:0]   r_dout;
  logic [7:0]          r_mem [DEPTH_BYTES];

  logic                w_acc;
  logic                w_size_bad;
  logic                w_mis;
  logic                w_rng;
  logic                w_fault;
  logic                w_do_wr;
  logic [ADDR_W-1:0]   w_amask;
  logic [ADDR_W:0]     w_end;
  logic [c_BA_W-1:0]   w_idx;
  int                  w_n;
  int                  w_shamt;
  logic [c_BIT_W-1:0]  w_sbit;
  logic [DATA_W-1:0]   w_be;
  logic [DATA_W-1:0]   w_raw;
  logic [DATA_W-1:0]   w_lo_mask;
  logic                w_sign;
  logic [DATA_W-1:0]   w_ext;
  logic [DATA_W-1:0]   w_wr_al;

  // The size is illegal when it exceeds the bus width. The address is
  // misaligned when any of its low log2(n) bits is set. The end address is
  // computed one bit wider so that it cannot wrap.
  assign w_size_bad = (bus.mem_size > c_SZ_MAX);
  assign w_amask    = ~({ADDR_W{1'b1}} << bus.mem_size);
  assign w_mis      = w_size_bad | (|(bus.address & w_amask));
  assign w_end      = {1'b0, bus.address} + ((ADDR_W + 1)'(1) << bus.mem_size);
  assign w_rng      = (w_end > c_DEPTH);
  assign w_fault    = w_mis | w_rng;
  assign w_acc      = r_ready & (bus.mem_read | bus.mem_write);
  assign w_do_wr    = w_acc & bus.mem_write & ~w_fault;
  assign w_idx      = bus.address[c_BA_W-1:0];

  // Gather the bytes at the address MSB-first, right-justify them to the
  // access size, and extend them. Store data is left-justified so that
  // byte k of the access always sits in lane c_NB-1-k.
  always_comb begin
    w_n       = w_size_bad ? c_NB : (1 << bus.mem_size);
    w_shamt   = 8 * (c_NB - w_n);
    w_sbit    = c_BIT_W'(8 * w_n - 1);
    w_be      = '0;
    for (int k = 0; k < c_NB; k++) begin
      w_be[8*(c_NB-1-k) +: 8] = r_mem[w_idx + c_BA_W'(k)];
    end
    w_raw     = w_be >> w_shamt;
    w_lo_mask = {DATA_W{1'b1}} >> w_shamt;
    w_sign    = bus.mem_signed & w_raw[w_sbit];
    w_ext     = w_sign ? (w_raw | ~w_lo_mask) : w_raw;
    w_wr_al   = bus.din << w_shamt;
  end

  // Array update. The init sequencer clears one word per cycle, and
  // accepted stores commit at the edge. Accesses are only accepted in IDLE,
  // so the two never collide.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      for (int k = 0; k < c_NB; k++) begin
        r_mem[c_BA_W'(int'(r_init_cnt) * c_NB + k)] <= 8'h00;
      end
    end else if (w_do_wr) begin
      for (int k = 0; k < c_NB; k++) begin
        if (k < w_n) begin
          r_mem[w_idx + c_BA_W'(k)] <= w_wr_al[8*(c_NB-1-k) +: 8];
        end
      end
    end
  end

  // Control FSM: the init sweep, then accept requests and register the
  // load result and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_ready      <= 1'b0;
      r_dout_valid <= 1'b0;
      r_err_mis    <= 1'b0;
      r_err_rng    <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      r_err_mis    <= 1'b0;
      r_err_rng    <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + c_CNT_W'(1);
          if (r_init_cnt == c_LAST) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_init_cnt <= '0;
          end
        end
        ST_IDLE: begin
          if (w_acc) begin
            r_err_mis <= w_mis;
            r_err_rng <= ~w_mis & w_rng;
            if (bus.mem_read) begin
              r_dout_valid <= 1'b1;
              r_dout       <= w_fault ? '0 : w_ext;
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.ready        = r_ready;
  assign bus.dout         = r_dout;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.err_misalign = r_err_mis;
  assign bus.err_range    = r_err_rng;
endmodule
`default_nettype wire
